// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADD_SHIFT = 2'd1,
    DONE      = 2'd2
  } mul_state_t;

  localparam int MUL_WIDTH = 16;
  localparam int MUL_STEPS = 16;

endpackage

// File: rtl/carry_select_adder.sv
// Carry-select adder built from 4-bit blocks; every block above the first
// precomputes both carry-in cases and picks one from the incoming carry.
module carry_select_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic [WIDTH-1:0] Sum,
  output logic             CO
);

  localparam int BLK  = 4;
  localparam int NBLK = WIDTH / BLK;

  logic [NBLK:0] c;

  assign c[0] = CI;

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    logic [BLK:0] r0;
    logic [BLK:0] r1;

    assign r0 = {1'b0, A[j*BLK +: BLK]} + {1'b0, B[j*BLK +: BLK]};
    assign r1 = {1'b0, A[j*BLK +: BLK]} + {1'b0, B[j*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
    assign Sum[j*BLK +: BLK] = c[j] ? r1[BLK-1:0] : r0[BLK-1:0];
    assign c[j+1]            = c[j] ? r1[BLK]     : r0[BLK];
  end

  assign CO = c[NBLK];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the shift-add multiplier: IDLE -> ADD_SHIFT (16 steps) -> DONE.
// Handshake: start is sampled only in IDLE; done is a one-cycle pulse after the last step.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       load,
  output logic       shift,
  output logic [1:0] state_dbg
);

  mul_state_t       state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          count_nxt = '0;
          state_nxt = ADD_SHIFT;
        end
      end
      ADD_SHIFT: begin
        shift     = 1'b1;
        count_nxt = count + {{(CNT_W-1){1'b0}}, 1'b1};
        if (count == CNT_W'(MUL_STEPS - 1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status decoded from the state register only, never from start.
  assign busy      = (state == ADD_SHIFT);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: rtl/shift_add_multiplier.sv
// 16x16 unsigned sequential multiplier: one add-shift step per clock through
// carry_select_adder; product register {ahi, q} holds until the next accepted start.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state_dbg
);

  if (WIDTH != MUL_WIDTH) begin : g_bad_width
    $error("shift_add_multiplier: WIDTH must equal the adder width (16)");
  end
  if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt
    $error("shift_add_multiplier: CNT_W too small for WIDTH steps");
  end

  logic             load, shift;
  logic [WIDTH-1:0] m_reg, ahi, q_reg;
  logic [WIDTH-1:0] add_sum;
  logic             add_co;
  logic [WIDTH:0]   step_hi;

  mul_seq_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk       (Clk),
    .rst       (Reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .load      (load),
    .shift     (shift),
    .state_dbg (state_dbg)
  );

  carry_select_adder #(.WIDTH(WIDTH)) u_adder (
    .A   (ahi),
    .B   (m_reg),
    .CI  (1'b0),
    .Sum (add_sum),
    .CO  (add_co)
  );

  // The adder carry becomes the top bit of the shifted result so 0xFFFF*0xFFFF stays exact.
  assign step_hi = q_reg[0] ? {add_co, add_sum} : {1'b0, ahi};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_reg <= '0;
      ahi   <= '0;
      q_reg <= '0;
    end else if (load) begin
      m_reg <= multiplicand;
      ahi   <= '0;
      q_reg <= multiplier;
    end else if (shift) begin
      {ahi, q_reg} <= {step_hi, q_reg[WIDTH-1:1]};
    end
  end

  assign product = {ahi, q_reg};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed table plus corner sequences and a random scoreboard for shift_add_multiplier.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  shift_add_multiplier dut (
    .Clk          (clk),
    .Reset        (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one start, then watches up to 40 cycles; lat is the cycle index of done (0 = never).
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] p, output int lat, output int nbusy);
    p = '0;
    lat = 0;
    nbusy = 0;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (lat == 0) begin
        if (busy) nbusy++;
        if (done) begin
          lat = i;
          p   = product;
        end
      end
      if (lat == 0) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] e;
    int lat, nbusy, ndone, dlat;
    logic [15:0] ra, rb;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h0000, 16'hABCD, 32'h0000_0000};
    vecs[3] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[6] = '{16'h00FF, 16'h0100, 32'h0000_FF00};
    vecs[7] = '{16'h1234, 16'h0010, 32'h0001_2340};
    vecs[8] = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[9] = '{16'hAAAA, 16'h5555, 32'h38E3_1C72};

    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_product", product, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_done", {31'b0, done}, 32'h0);
    end

    foreach (vecs[i]) begin
      do_mul(vecs[i].a, vecs[i].b, p, lat, nbusy);
      check($sformatf("vec%0d_product", i), p, vecs[i].exp);
      check($sformatf("vec%0d_done_cycle", i), lat, 17);
      check($sformatf("vec%0d_busy_cycles", i), nbusy, 16);
    end

    // Operand change and a second start while busy must be ignored.
    @(negedge clk);
    multiplicand = 16'h1234;
    multiplier   = 16'h0010;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    dlat = 0;
    p = '0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        ndone++;
        if (dlat == 0) begin
          dlat = i;
          p = product;
        end
      end
      if (i == 5) begin
        multiplicand = 16'hFFFF;
        multiplier   = 16'hFFFF;
        start        = 1'b1;
      end else if (i == 6) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check("ignore_product", p, 32'h0001_2340);
    check("ignore_done_pulses", ndone, 1);
    check("ignore_done_cycle", dlat, 17);
    check("ignore_idle_after", {31'b0, busy}, 32'h0);
    check("ignore_product_held", product, 32'h0001_2340);

    // Reset mid-operation aborts immediately with no done pulse.
    multiplicand = 16'h0007;
    multiplier   = 16'h0009;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy_before", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_product", product, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle_product", product, 32'h0);
    do_mul(16'h0002, 16'h0002, p, lat, nbusy);
    check("post_abort_product", p, 32'h0000_0004);
    check("post_abort_done_cycle", lat, 17);

    // Random back-to-back operations against an expected queue.
    for (int n = 0; n < 1000; n++) begin
      ra = (n % 8 == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      e = {16'h0, ra} * {16'h0, rb};
      exp_q.push_back(e);
      do_mul(ra, rb, p, lat, nbusy);
      check($sformatf("rand%0d_done_cycle", n), lat, 17);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("rand%0d_product_%h_%h", n, ra, rb), p, e);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
